// File: rtl/ltc2308_responder_if.sv
// Serial link between an LTC2308-style ADC master and the responder model.
// The master drives convst/sck/sdi; the responder returns result bits on sdo.
interface ltc2308_responder_if;
  logic convst;
  logic sck;
  logic sdi;
  logic sdo;

  modport master (
    output convst,
    output sck,
    output sdi,
    input  sdo
  );

  modport slave (
    input  convst,
    input  sck,
    input  sdi,
    output sdo
  );
endinterface

// File: rtl/ltc2308_responder.sv
// Behavioural LTC2308 responder: synchronises the master's serial pins, runs a
// timed conversion and shifts the 12-bit result out while a new config shifts in.
module ltc2308_responder #(
  parameter int unsigned CONV_CYCLES = 80
) (
  input  logic               clk,
  input  logic               reset_n,
  ltc2308_responder_if.slave bus,
  input  logic [11:0]        adc_src,
  output logic [2:0]         ch_sel,
  output logic [5:0]         cfg,
  output logic               busy,
  output logic               conv_done
);

  localparam int unsigned    CW        = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
  localparam logic [CW-1:0]  CNT_LOAD  = CW'(CONV_CYCLES - 1);
  localparam logic [5:0]     CFG_RESET = 6'b100010;
  localparam logic [2:0]     CFG_BITS  = 3'd6;
  localparam logic [3:0]     OUT_BITS  = 4'd12;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    READY
  } state_t;

  state_t state, state_next;

  logic [1:0] convst_sync;
  logic [1:0] sck_sync;
  logic [1:0] sdi_sync;
  logic       convst_d;
  logic       sck_d;
  logic [2:0] sync_vld;

  logic convst_s, sck_s, sdi_s;
  logic convst_rise, sck_rise, sck_fall;

  logic [CW-1:0] cnt;
  logic [5:0]    stage;
  logic [2:0]    in_cnt;
  logic [11:0]   sr;
  logic [3:0]    out_cnt;

  logic enter_conv;
  logic capture;
  logic shift_in;
  logic shift_out;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      convst_sync <= '0;
      sck_sync    <= '0;
      sdi_sync    <= '0;
      convst_d    <= 1'b0;
      sck_d       <= 1'b0;
      sync_vld    <= '0;
    end else begin
      convst_sync <= {convst_sync[0], bus.convst};
      sck_sync    <= {sck_sync[0], bus.sck};
      sdi_sync    <= {sdi_sync[0], bus.sdi};
      convst_d    <= convst_sync[1];
      sck_d       <= sck_sync[1];
      sync_vld    <= {sync_vld[1:0], 1'b1};
    end
  end

  assign convst_s = convst_sync[1];
  assign sck_s    = sck_sync[1];
  assign sdi_s    = sdi_sync[1];

  // Edges are qualified until the pipeline holds real pin history, so a
  // convst already high at reset release does not look like a rising edge.
  assign convst_rise = sync_vld[2] &  convst_s & ~convst_d;
  assign sck_rise    = sync_vld[2] &  sck_s    & ~sck_d;
  assign sck_fall    = sync_vld[2] & ~sck_s    &  sck_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    enter_conv = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (convst_rise) begin
          enter_conv = 1'b1;
          state_next = CONVERT;
        end
      end
      CONVERT: begin
        if (cnt == '0) begin
          capture    = 1'b1;
          state_next = READY;
        end
      end
      READY: begin
        if (convst_rise) begin
          enter_conv = 1'b1;
          state_next = CONVERT;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A convst edge in the same cycle wins; the coincident sck edge is dropped.
  assign shift_in  = (state == READY) && sck_rise && !convst_rise && (in_cnt < CFG_BITS);
  assign shift_out = (state == READY) && sck_fall && !convst_rise && (out_cnt < OUT_BITS);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= '0;
      cfg     <= CFG_RESET;
      stage   <= '0;
      in_cnt  <= '0;
      sr      <= '0;
      out_cnt <= '0;
    end else begin
      if (enter_conv) begin
        cnt    <= CNT_LOAD;
        in_cnt <= '0;
        if (in_cnt == CFG_BITS) begin
          cfg <= stage;
        end
      end else if ((state == CONVERT) && (cnt != '0)) begin
        cnt <= cnt - CW'(1);
      end

      if (capture) begin
        sr      <= cfg[1] ? adc_src : (adc_src ^ 12'h800);
        out_cnt <= '0;
      end

      if (shift_in) begin
        stage  <= {stage[4:0], sdi_s};
        in_cnt <= in_cnt + 3'd1;
      end

      if (shift_out) begin
        sr      <= {sr[10:0], 1'b0};
        out_cnt <= out_cnt + 4'd1;
      end
    end
  end

  always_comb begin
    bus.sdo   = 1'b0;
    busy      = (state == CONVERT);
    conv_done = capture;
    if ((state == READY) && !convst_s && (out_cnt < OUT_BITS)) begin
      bus.sdo = sr[11];
    end
  end

  // Channel index is {S1,S0,O/S} regardless of single-ended/differential mode.
  assign ch_sel = {cfg[3], cfg[2], cfg[4]};

endmodule

// File: tb/tb_ltc2308_responder.sv
// Scoreboard bench for ltc2308_responder: directed conversions, config loads,
// partial transfers, ignored edges and reset abort.
module tb_ltc2308_responder;

  localparam int unsigned CONV = 80;

  logic        clk;
  logic        reset_n;
  logic [11:0] adc_src;
  logic [2:0]  ch_sel;
  logic [5:0]  cfg;
  logic        busy;
  logic        conv_done;
  logic [11:0] chan_val [0:7];

  ltc2308_responder_if bus ();

  ltc2308_responder #(.CONV_CYCLES(CONV)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .adc_src   (adc_src),
    .ch_sel    (ch_sel),
    .cfg       (cfg),
    .busy      (busy),
    .conv_done (conv_done)
  );

  assign adc_src = chan_val[ch_sel];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_read;
    logic [5:0]  cfg;
    logic [2:0]  ch;
    logic [15:0] val;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  logic [15:0] rd_word;
  logic        rd_valid;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: event without matching expectation", name);
  endtask

  task automatic exp_conv(input logic [5:0] c, input logic [2:0] ch);
    exp_t e;
    e.is_read = 1'b0;
    e.cfg     = c;
    e.ch      = ch;
    e.val     = '0;
    q.push_back(e);
  endtask

  task automatic exp_read(input logic [15:0] v);
    exp_t e;
    e.is_read = 1'b1;
    e.cfg     = '0;
    e.ch      = '0;
    e.val     = v;
    q.push_back(e);
  endtask

  // Monitor: pops an expectation whenever the DUT signals a conversion or a
  // completed master read is published.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1 && conv_done === 1'b1) begin
        if (q.size() == 0 || q[0].is_read) begin
          fail_now("conv_done");
        end else begin
          e = q.pop_front();
          chk("conv_cfg", {10'd0, cfg}, {10'd0, e.cfg});
          chk("conv_ch_sel", {13'd0, ch_sel}, {13'd0, e.ch});
        end
      end
      if (rd_valid === 1'b1) begin
        if (q.size() == 0 || !q[0].is_read) begin
          fail_now("read_word");
        end else begin
          e = q.pop_front();
          chk("read_word", rd_word, e.val);
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic convert_and_wait();
    int  cyc;
    bit  seen;
    bit  done;
    cyc  = 0;
    seen = 1'b0;
    done = 1'b0;
    @(posedge clk);
    #1 bus.convst = 1'b1;
    for (int i = 0; i < 300 && !done; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (i == 3) bus.convst = 1'b0;
      if (busy) seen = 1'b1;
      else if (seen) done = 1'b1;
    end
    chk("busy_len", {15'd0, (done && cyc >= CONV && cyc <= CONV + 6)}, 16'd1);
  endtask

  task automatic xfer(input int n, input logic [5:0] cw, input int ncfg);
    logic [15:0] word;
    word = '0;
    for (int i = 0; i < n; i++) begin
      bus.sdi = (i < ncfg) ? cw[5 - i] : 1'b0;
      cycles(6);
      bus.sck = 1'b1;
      cycles(6);
      word = {word[14:0], bus.sdo};
      bus.sck = 1'b0;
    end
    bus.sdi = 1'b0;
    cycles(6);
    rd_word  = word;
    rd_valid = 1'b1;
    cycles(1);
    rd_valid = 1'b0;
  endtask

  initial begin
    int busy_hits;
    bit seen;
    reset_n    = 1'b0;
    bus.convst = 1'b0;
    bus.sck    = 1'b0;
    bus.sdi    = 1'b0;
    rd_word    = '0;
    rd_valid   = 1'b0;
    for (int i = 0; i < 8; i++) chan_val[i] = 12'h123 + 12'(i);

    cycles(3);
    chk("rst_sdo", {15'd0, bus.sdo}, 16'd0);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_conv_done", {15'd0, conv_done}, 16'd0);
    chk("rst_cfg", {10'd0, cfg}, 16'h0022);
    chk("rst_ch_sel", {13'd0, ch_sel}, 16'd0);
    reset_n = 1'b1;
    cycles(5);

    // Basic conversion, 14 reads (last two must be zero); loads cfg 110000.
    chan_val[0] = 12'hA5C;
    exp_conv(6'b100010, 3'd0);
    convert_and_wait();
    exp_read(16'h2970);
    xfer(14, 6'b110000, 6);

    // Bipolar CH1, zero sample reads 800; loads cfg 100110.
    chan_val[1] = 12'h000;
    exp_conv(6'b110000, 3'd1);
    convert_and_wait();
    exp_read(16'h0800);
    xfer(12, 6'b100110, 6);

    // Unipolar CH2; partial read of 5 bits with only 5 config bits.
    chan_val[2] = 12'h3C1;
    exp_conv(6'b100110, 3'd2);
    convert_and_wait();
    exp_read(16'h0007);
    xfer(5, 6'b010110, 5);

    // cfg unchanged after partial config; new sample read MSB first.
    chan_val[2] = 12'hF0F;
    exp_conv(6'b100110, 3'd2);
    convert_and_wait();
    exp_read(16'h0F0F);
    xfer(12, 6'b111101, 6);

    // Bipolar CH7 with sck toggles and a second convst during CONVERT.
    chan_val[7] = 12'h7FF;
    exp_conv(6'b111101, 3'd7);
    fork
      convert_and_wait();
      begin
        cycles(20);
        bus.sdi = 1'b1;
        for (int k = 0; k < 4; k++) begin
          bus.sck = 1'b1;
          cycles(6);
          bus.sck = 1'b0;
          cycles(6);
        end
        bus.sdi = 1'b0;
        bus.convst = 1'b1;
        cycles(4);
        bus.convst = 1'b0;
      end
    join
    exp_read(16'h0FFF);
    xfer(12, 6'b000000, 0);

    // Reset at counter 40 aborts with no conv_done; held convst does not restart.
    cycles(2);
    bus.convst = 1'b1;
    cycles(3);
    bus.convst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (busy) seen = 1'b1;
      else cycles(1);
    end
    chk("abort_busy_seen", {15'd0, seen}, 16'd1);
    cycles(39);
    reset_n    = 1'b0;
    bus.convst = 1'b1;
    #2;
    chk("abort_busy", {15'd0, busy}, 16'd0);
    chk("abort_cfg", {10'd0, cfg}, 16'h0022);
    chk("abort_ch_sel", {13'd0, ch_sel}, 16'd0);
    chk("abort_conv_done", {15'd0, conv_done}, 16'd0);
    cycles(1);
    reset_n = 1'b1;
    busy_hits = 0;
    for (int i = 0; i < 120; i++) begin
      cycles(1);
      if (busy) busy_hits++;
    end
    chk("held_convst_no_start", 16'(busy_hits), 16'd0);
    bus.convst = 1'b0;
    cycles(10);

    // Normal conversion after reset uses default config.
    chan_val[0] = 12'h001;
    exp_conv(6'b100010, 3'd0);
    convert_and_wait();
    exp_read(16'h0001);
    xfer(12, 6'b000000, 0);

    cycles(20);
    chk("pending_expectations", 16'(q.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
